pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter SyncStages, default 2: number of flip-flop synchronizer stages on each S input (legal range 2..4).
REQ-002 Parameter TimeoutCount, default 16'hFFFF: cycle count at which a measurement is abandoned.
REQ-003 MClk  input  1  system clock; all logic is on the rising edge.
REQ-004 RstN  input  1  reset, synchronous, active-low.
REQ-005 En  input  1  capture enable; when low, no new measurement starts.
REQ-006 S  input  2  complementary gate pair from a PWM level generator, asynchronous to MClk: S[0] is the main switch, S[1] is the complement.
REQ-007 Ack  input  1  consumer acknowledge for the current result.
REQ-008 Period  output  16  MClk cycles between consecutive S[0] rising edges.
REQ-009 HighTime  output  16  MClk cycles S[0] was high within the period.
REQ-010 DeadTime  output  16  MClk cycles both S[0] and S[1] were low immediately before the closing S[0] rise.
REQ-011 Valid  output  1  Period, HighTime and DeadTime hold a result not yet acknowledged.
REQ-012 Fault  output  1  sticky flag: S[0] and S[1] were observed high simultaneously.
REQ-013 Timeout  output  1  sticky flag: a measurement exceeded TimeoutCount.
REQ-014 Overrun  output  1  sticky flag: a result was dropped because Valid was high with no Ack.

Function
REQ-015 Synchronization: S[0] and S[1] each pass through SyncStages flip-flops; all edge detection and counting use the synchronized copies (s0, s1).
REQ-016 Edge detect: one additional register per bit; a rise is current=1 and previous=0, a fall is the reverse.
REQ-017 States: IDLE, HIGH, LOW.
REQ-018 IDLE -> HIGH on an s0 rise while En=1; counters PerCnt=1, HiCnt=1, DtCnt=0.
REQ-019 HIGH: PerCnt and HiCnt increment each cycle; on an s0 fall, go to LOW.
REQ-020 LOW: PerCnt increments each cycle; DtCnt increments while s0=0 and s1=0, and is cleared to 0 on any cycle with s1=1.
REQ-021 LOW -> HIGH on an s0 rise: publish Period=PerCnt, HighTime=HiCnt, DeadTime=DtCnt; the new measurement starts in the same cycle (PerCnt=1, HiCnt=1, DtCnt=0) with no lost edge.
REQ-022 Publish timing: the outputs and Valid update on the clock edge following the cycle in which the closing rise is detected.
REQ-023 Counter width: 16 bits. If PerCnt reaches TimeoutCount, set Timeout, go to IDLE, and publish nothing; counters never wrap.
REQ-024 Fault is set on any cycle with s0=1 and s1=1, in any state, whether En is high or low; measurement continues unaffected.
REQ-025 Handshake: Valid stays high until a cycle with Ack=1, and clears on the next edge unless a new publish occurs in that same cycle.
REQ-026 Publish with Valid=1 and Ack=1 in the same cycle: load the new result, keep Valid=1, leave Overrun unchanged.
REQ-027 Publish with Valid=1 and Ack=0: keep the old outputs unchanged and set Overrun.
REQ-028 Ack while Valid=0 is ignored.
REQ-029 En deasserted in HIGH or LOW: go to IDLE on the next edge and discard the partial measurement; Valid and the published outputs are retained.
REQ-030 Sticky flags clear only on reset.

Reset
REQ-031 With RstN=0 at a clock edge: state=IDLE; all counters, Period, HighTime, DeadTime = 0; Valid, Fault, Timeout, Overrun = 0; synchronizer and edge registers = 0.
REQ-032 Reset mid-measurement discards the partial count. The first publish after reset requires one s0 rise to start the measurement and a second s0 rise to close it.
REQ-033 No output may assert X after the first reset edge.

Verification
REQ-034 Stimulus: En=1; S[0] period 100 cycles, high 30 cycles; S[1] is the complement with 5-cycle gaps around each S[0] edge. Required: Valid with Period=100, HighTime=30, DeadTime=5.
REQ-035 Stimulus: S[0] and S[1] both high for 1 cycle. Required: Fault=1 and stays set; the next period still reports correct values.
REQ-036 Stimulus: Ack held low across two periods. Required: the first result is retained, Overrun=1. Then pulse Ack exactly on the next publish cycle. Required: the new values load, Valid stays 1.
REQ-037 Stimulus: TimeoutCount=200 and S[0] held high 300 cycles. Required: Timeout=1, state returns to IDLE, Valid is unchanged.
REQ-038 Stimulus: RstN pulsed low at cycle 50 of a 100-cycle period. Required: all outputs read 0. The next Valid appears only after two further s0 rises, with correct values.
REQ-039 Stimulus: En dropped mid-HIGH, then raised again. Required: no publish for the aborted period; the next full period is reported correctly.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM gate-pair capture: measures period, high time and dead time of a complementary
// S[0]/S[1] pair and hands each result to a consumer with a Valid/Ack handshake.
module pwm_capture #(
    parameter int unsigned SyncStages   = 2,
    parameter logic [15:0] TimeoutCount = 16'hFFFF
) (
    input  logic        MClk,
    input  logic        RstN,
    input  logic        En,
    input  logic [1:0]  S,
    input  logic        Ack,
    output logic [15:0] Period,
    output logic [15:0] HighTime,
    output logic [15:0] DeadTime,
    output logic        Valid,
    output logic        Fault,
    output logic        Timeout,
    output logic        Overrun,
    output logic [1:0]  DbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } captureState_t;

    captureState_t state, stateNext;

    logic [SyncStages-1:0] s0Sync, s1Sync;
    logic                  s0, s1, s0Prev, s1Prev;
    logic                  s0Rise, s0Fall;
    logic [15:0]           perCnt, hiCnt, dtCnt;
    logic [15:0]           perNext, hiNext, dtNext;
    logic                  publish, timeoutHit;

    assign s0       = s0Sync[SyncStages-1];
    assign s1       = s1Sync[SyncStages-1];
    assign s0Rise   = s0 & ~s0Prev;
    assign s0Fall   = ~s0 & s0Prev;
    assign DbgState = state;

    // Handshake: a result is offered while Valid=1 and is consumed on any edge
    // that samples Ack=1; a publish that finds Valid=1 and Ack=0 is dropped (Overrun).
    always_comb begin
        stateNext  = state;
        perNext    = perCnt;
        hiNext     = hiCnt;
        dtNext     = dtCnt;
        publish    = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (En && s0Rise) begin
                    stateNext = HIGH;
                    perNext   = 16'd1;
                    hiNext    = 16'd1;
                    dtNext    = 16'd0;
                end
            end
            HIGH, LOW: begin
                if (!En) begin
                    stateNext = IDLE;
                end else if (perCnt >= TimeoutCount) begin
                    timeoutHit = 1'b1;
                    stateNext  = IDLE;
                end else if (state == LOW && s0Rise) begin
                    // Closing rise doubles as the opening rise of the next period.
                    publish   = 1'b1;
                    stateNext = HIGH;
                    perNext   = 16'd1;
                    hiNext    = 16'd1;
                    dtNext    = 16'd0;
                end else begin
                    perNext = perCnt + 16'd1;
                    if (state == HIGH) begin
                        if (s0Fall) begin
                            stateNext = LOW;
                        end else begin
                            hiNext = hiCnt + 16'd1;
                        end
                    end else if (s1) begin
                        dtNext = 16'd0;
                    end else if (!s0) begin
                        dtNext = dtCnt + 16'd1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge MClk) begin
        if (!RstN) begin
            s0Sync   <= '0;
            s1Sync   <= '0;
            s0Prev   <= 1'b0;
            s1Prev   <= 1'b0;
            state    <= IDLE;
            perCnt   <= 16'd0;
            hiCnt    <= 16'd0;
            dtCnt    <= 16'd0;
            Period   <= 16'd0;
            HighTime <= 16'd0;
            DeadTime <= 16'd0;
            Valid    <= 1'b0;
            Fault    <= 1'b0;
            Timeout  <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            s0Sync <= {s0Sync[SyncStages-2:0], S[0]};
            s1Sync <= {s1Sync[SyncStages-2:0], S[1]};
            s0Prev <= s0;
            s1Prev <= s1;
            state  <= stateNext;
            perCnt <= perNext;
            hiCnt  <= hiNext;
            dtCnt  <= dtNext;
            if (s0 && s1) begin
                Fault <= 1'b1;
            end
            if (timeoutHit) begin
                Timeout <= 1'b1;
            end
            if (publish) begin
                if (Valid && !Ack) begin
                    Overrun <= 1'b1;
                end else begin
                    Period   <= perCnt;
                    HighTime <= hiCnt;
                    DeadTime <= dtCnt;
                    Valid    <= 1'b1;
                end
            end else if (Ack) begin
                Valid <= 1'b0;
            end
        end
    end

    // s1Prev completes the per-bit edge register pair; no s1 edge is consumed today.
    logic unusedS1Prev;
    assign unusedS1Prev = s1Prev;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives whole PWM periods and checks published results,
// handshake, sticky flags, timeout, enable abort and mid-period reset.
module tb_pwm_capture;

    logic        MClk = 1'b0;
    logic        RstN;
    logic        En;
    logic [1:0]  S;
    logic        Ack;
    logic [15:0] Period, HighTime, DeadTime;
    logic        Valid, Fault, Timeout, Overrun;
    logic [1:0]  DbgState;

    int tests = 0;
    int fails = 0;

    // Values captured by run_period at fixed offsets from the period's opening rise.
    logic        v2, v3, vEnd, fEnd, tEnd, oEnd;
    logic [15:0] p3, h3, d3, pEnd;
    logic [1:0]  stEnd;
    logic [55:0] zcap;

    pwm_capture #(.SyncStages(2), .TimeoutCount(16'd200)) dut (
        .MClk(MClk), .RstN(RstN), .En(En), .S(S), .Ack(Ack),
        .Period(Period), .HighTime(HighTime), .DeadTime(DeadTime),
        .Valid(Valid), .Fault(Fault), .Timeout(Timeout), .Overrun(Overrun),
        .DbgState(DbgState)
    );

    always #5 MClk = ~MClk;

    // One PWM period: S[0] high for hi cycles, S[1] the complement with gap-cycle
    // dead bands (gap=-1 overlaps the gates by one cycle at the S[0] fall).
    // A result published by this period's opening rise is visible at index 3.
    task automatic run_period(input int per, input int hi, input int gap, input int ackAt,
                              input int enOffFrom, input int enOffTo, input int rstAt);
        for (int i = 0; i < per; i++) begin
            @(negedge MClk);
            if (i == 2) v2 = Valid;
            if (i == 3) begin
                v3 = Valid; p3 = Period; h3 = HighTime; d3 = DeadTime;
            end
            if (rstAt >= 0 && i == rstAt + 1)
                zcap = {Period, HighTime, DeadTime, Valid, Fault, Timeout, Overrun, DbgState, 2'b00};
            if (i == per - 1) begin
                vEnd = Valid; pEnd = Period; fEnd = Fault; tEnd = Timeout;
                oEnd = Overrun; stEnd = DbgState;
            end
            S[0] = (i < hi);
            S[1] = (i >= hi + gap) && (i < per - gap);
            Ack  = (i == ackAt);
            En   = !((i >= enOffFrom) && (i <= enOffTo));
            RstN = (i != rstAt);
        end
    endtask

    task automatic test_reset();
        RstN = 1'b0; En = 1'b1; S = 2'b00; Ack = 1'b0;
        repeat (4) @(negedge MClk);
        tests++; if (Period !== 16'd0) begin fails++; $display("FAIL reset_period: got %0d expected 0", Period); end
        tests++; if (HighTime !== 16'd0 || DeadTime !== 16'd0) begin fails++; $display("FAIL reset_times: got %0d/%0d expected 0/0", HighTime, DeadTime); end
        tests++; if ({Valid, Fault, Timeout, Overrun} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {Valid, Fault, Timeout, Overrun}); end
        tests++; if (DbgState !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", DbgState); end
        RstN = 1'b1;
        repeat (4) @(negedge MClk);
    endtask

    task automatic test_basic();
        run_period(100, 30, 5, -1, -1, -1, -1);
        tests++; if (v3 !== 1'b0) begin fails++; $display("FAIL basic_no_publish_on_open: got %b expected 0", v3); end
        run_period(100, 30, 5, 10, -1, -1, -1);
        tests++; if (v2 !== 1'b0 || v3 !== 1'b1) begin fails++; $display("FAIL basic_publish_timing: got %b%b expected 01", v2, v3); end
        tests++; if (p3 !== 16'd100 || h3 !== 16'd30 || d3 !== 16'd5) begin fails++; $display("FAIL basic_values: got %0d/%0d/%0d expected 100/30/5", p3, h3, d3); end
        tests++; if (vEnd !== 1'b0 || oEnd !== 1'b0) begin fails++; $display("FAIL basic_ack_clear: got valid=%b overrun=%b expected 0 0", vEnd, oEnd); end
    endtask

    task automatic test_varied();
        run_period(80, 20, 3, 10, -1, -1, -1);
        run_period(50, 10, 2, 10, -1, -1, -1);
        tests++; if (v3 !== 1'b1 || p3 !== 16'd80 || h3 !== 16'd20 || d3 !== 16'd3) begin fails++; $display("FAIL varied_values: got v=%b %0d/%0d/%0d expected v=1 80/20/3", v3, p3, h3, d3); end
        tests++; if (fEnd !== 1'b0) begin fails++; $display("FAIL varied_no_fault: got %b expected 0", fEnd); end
    endtask

    task automatic test_fault();
        run_period(60, 20, -1, 10, -1, -1, -1);
        tests++; if (p3 !== 16'd50 || h3 !== 16'd10 || d3 !== 16'd2) begin fails++; $display("FAIL fault_prev_values: got %0d/%0d/%0d expected 50/10/2", p3, h3, d3); end
        tests++; if (fEnd !== 1'b1) begin fails++; $display("FAIL fault_set: got %b expected 1", fEnd); end
        run_period(70, 25, 4, 10, -1, -1, -1);
        tests++; if (p3 !== 16'd60 || h3 !== 16'd20 || d3 !== 16'd0) begin fails++; $display("FAIL fault_period_values: got %0d/%0d/%0d expected 60/20/0", p3, h3, d3); end
        tests++; if (fEnd !== 1'b1) begin fails++; $display("FAIL fault_sticky: got %b expected 1", fEnd); end
    endtask

    task automatic test_overrun();
        run_period(90, 40, 6, -1, -1, -1, -1);
        tests++; if (p3 !== 16'd70 || h3 !== 16'd25 || d3 !== 16'd4) begin fails++; $display("FAIL after_fault_values: got %0d/%0d/%0d expected 70/25/4", p3, h3, d3); end
        tests++; if (vEnd !== 1'b1 || oEnd !== 1'b0) begin fails++; $display("FAIL overrun_pre: got valid=%b overrun=%b expected 1 0", vEnd, oEnd); end
        run_period(100, 30, 5, -1, -1, -1, -1);
        tests++; if (p3 !== 16'd70 || h3 !== 16'd25 || d3 !== 16'd4) begin fails++; $display("FAIL overrun_retain: got %0d/%0d/%0d expected 70/25/4", p3, h3, d3); end
        tests++; if (oEnd !== 1'b1 || vEnd !== 1'b1) begin fails++; $display("FAIL overrun_set: got overrun=%b valid=%b expected 1 1", oEnd, vEnd); end
        run_period(40, 15, 2, 2, -1, -1, -1);
        tests++; if (p3 !== 16'd100 || h3 !== 16'd30 || d3 !== 16'd5) begin fails++; $display("FAIL ack_on_publish_load: got %0d/%0d/%0d expected 100/30/5", p3, h3, d3); end
        tests++; if (v3 !== 1'b1 || vEnd !== 1'b1 || oEnd !== 1'b1) begin fails++; $display("FAIL ack_on_publish_flags: got v3=%b vEnd=%b ovr=%b expected 1 1 1", v3, vEnd, oEnd); end
    endtask

    task automatic test_en_abort();
        run_period(60, 20, 4, 10, -1, -1, -1);
        tests++; if (vEnd !== 1'b0 || pEnd !== 16'd100) begin fails++; $display("FAIL en_setup: got valid=%b period=%0d expected 0 100", vEnd, pEnd); end
        run_period(50, 20, 3, 10, 10, 12, -1);
        tests++; if (v3 !== 1'b1 || p3 !== 16'd60 || h3 !== 16'd20 || d3 !== 16'd4) begin fails++; $display("FAIL en_prev_values: got v=%b %0d/%0d/%0d expected v=1 60/20/4", v3, p3, h3, d3); end
        run_period(70, 30, 5, -1, -1, -1, -1);
        tests++; if (v3 !== 1'b0 || vEnd !== 1'b0) begin fails++; $display("FAIL en_aborted_no_publish: got %b/%b expected 0/0", v3, vEnd); end
        run_period(70, 30, 5, -1, -1, -1, -1);
        tests++; if (v3 !== 1'b1 || p3 !== 16'd70 || h3 !== 16'd30 || d3 !== 16'd5) begin fails++; $display("FAIL en_next_values: got v=%b %0d/%0d/%0d expected v=1 70/30/5", v3, p3, h3, d3); end
    endtask

    task automatic test_timeout();
        tests++; if (Timeout !== 1'b0) begin fails++; $display("FAIL timeout_pre: got %b expected 0", Timeout); end
        run_period(320, 300, 0, -1, -1, -1, -1);
        tests++; if (tEnd !== 1'b1 || stEnd !== 2'd0) begin fails++; $display("FAIL timeout_set: got timeout=%b state=%0d expected 1 0", tEnd, stEnd); end
        tests++; if (vEnd !== 1'b1 || pEnd !== 16'd70) begin fails++; $display("FAIL timeout_valid_kept: got valid=%b period=%0d expected 1 70", vEnd, pEnd); end
    endtask

    task automatic test_reset_mid();
        run_period(100, 30, 5, -1, -1, -1, -1);
        run_period(100, 30, 5, -1, -1, -1, 50);
        tests++; if (zcap !== 56'd0) begin fails++; $display("FAIL reset_mid_zero: got %h expected 0", zcap); end
        run_period(100, 30, 5, -1, -1, -1, -1);
        tests++; if (v3 !== 1'b0) begin fails++; $display("FAIL reset_mid_first_rise: got %b expected 0", v3); end
        run_period(100, 30, 5, -1, -1, -1, -1);
        tests++; if (v2 !== 1'b0 || v3 !== 1'b1 || p3 !== 16'd100 || h3 !== 16'd30 || d3 !== 16'd5) begin fails++; $display("FAIL reset_mid_values: got v=%b%b %0d/%0d/%0d expected v=01 100/30/5", v2, v3, p3, h3, d3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_varied();
        test_fault();
        test_overrun();
        test_en_abort();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
